mem_access_unit: RTL
====================

# mem_access_unit

Parametrised memory-access pipeline stage that sits between EX/MEM and WB and replaces the purely combinational memory stage. It adds the following:
- sub-word loads and stores with byte enables;
- sign or zero extension on loads;
- a request/acknowledge data-memory handshake with pipeline stall and bus timeout;
- misalignment detection;
- beq/bne branch resolution;
- a registered MEM/WB output bundle.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width (≥ 2)
- REG_ADDR_W, 5, register-file address width
- MAX_WAIT, 15, cycles in BUSY without ack before timeout (1..255)

Ports (data width fixed at 32, DW below):
- clk  in  1  clock; one clock domain
- nrst  in  1  reset, asynchronous, active-low
- i_valid  in  1  EX/MEM slot holds a live instruction
- i_MemRead, i_MemWrite  in  1 each  load / store (never both)
- i_Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- i_Unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- i_Branch, i_BranchNe  in  1 each  branch, and bne when i_BranchNe=1
- i_Zero  in  1  ALU zero flag
- i_PCBranch  in  ADDR_W  branch target
- i_ALUOut  in  DW  effective address / ALU result
- i_RTData  in  DW  store data
- i_Mem2Reg, i_RegWrite  in  1 each  WB controls
- i_RegAddrW  in  REG_ADDR_W  destination register
- o_stall  out  1  upstream must hold all inputs this cycle
- o_PCSrc  out  1  take branch
- o_PCBranch  out  ADDR_W  copy of i_PCBranch
- o_req, o_we  out  1 each  memory request / write
- o_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- o_wdata  out  DW  store data replicated across lanes
- o_be  out  4  byte enables
- i_ack  in  1  memory completes the request this cycle
- i_rdata  in  DW  read word, valid with i_ack
- o_wb_valid  out  1  WB bundle is live
- o_WB_MemData, o_WB_ALUData  out  DW each  extended load data / ALU result
- o_WB_Mem2Reg, o_WB_RegWrite  out  1 each  WB controls
- o_WB_RegAddrW  out  REG_ADDR_W  destination register
- o_misalign, o_timeout  out  1 each  one-cycle fault pulses

## Operation
- A mem op is i_valid & (i_MemRead | i_MemWrite).
- Alignment:
  - half requires addr[0]=0;
  - word requires addr[1:0]=0.
- FSM has two states, IDLE and BUSY.
- IDLE, aligned mem op:
  - o_stall=1;
  - latch address, byte enables, write data, we, lane, size, unsigned and WB controls;
  - go to BUSY.
- IDLE, misaligned mem op:
  - no request is issued;
  - o_misalign=1 next cycle;
  - o_wb_valid=0;
  - stay in IDLE.
- IDLE, non-mem op: the WB bundle loads at the next edge, with o_wb_valid=i_valid.
- BUSY:
  - o_req=1 with all bus outputs from the latched values;
  - o_stall = ~i_ack.
- BUSY, i_ack:
  - load the WB bundle, extracting the addressed lane and extending it (lane=addr[1:0] for bytes, addr[1] for halves);
  - a store retires with o_wb_valid=1 and RegWrite as supplied;
  - return to IDLE.
- BUSY, timeout: a wait counter reaching MAX_WAIT without ack causes:
  - o_req drops;
  - o_timeout pulses;
  - o_wb_valid=0;
  - return to IDLE.
- Byte enables:
  - byte: 1 shl lane;
  - half: 0011 or 1100;
  - word: 1111.
- o_wdata carries the byte replicated ×4, the half ×2, or the word.
- o_PCSrc = i_valid & i_Branch & (i_Zero ^ i_BranchNe). It is combinational and independent of FSM state.

## Timing
- Reset values: state IDLE, wait counter 0, and every registered output 0 (o_req, o_we, o_addr, o_wdata, o_be, all o_WB_*, o_wb_valid, o_misalign, o_timeout).
- Reset asserted mid-BUSY aborts the access immediately; no WB bundle is produced.
- Non-mem latency: 1 cycle to o_wb_valid.
- Mem op accepted in cycle 0:
  - o_req is high from cycle 1;
  - ack in cycle k (k≥1) gives o_wb_valid in cycle k+1;
  - minimum latency is 2.
- o_stall is combinational: high in cycle 0 and in every BUSY cycle without ack.
- o_wb_valid is a one-cycle pulse per retired instruction.
- Timeout: o_req is high for exactly MAX_WAIT cycles, and o_timeout pulses in the following cycle.
- i_ack outside BUSY is ignored.
- An ack in the same cycle the counter hits MAX_WAIT counts as success.

## Structure
- Shared package mips_pkg holds:
  - the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - the FSM state enum;
  - a WB-bundle struct.
- One sub-module, mem_lane_align, is pure combinational. It takes size, lane, unsigned, store data and read data, and produces byte enables, replicated write data, the extended load value and the misalign flag.

## Test plan
- Word load at 0x100, ack on cycle 3 with rdata 0xDEADBEEF:
  - o_stall high in cycles 0–2;
  - o_WB_MemData=0xDEADBEEF with o_wb_valid in cycle 4.
- Signed byte load at 0x103 with rdata 0x80112233 (the lane-3 byte is 0x80) gives MemData=0xFFFFFF80. The same load with i_Unsigned=1 gives 0x00000080.
- Half store of 0x1234ABCD at 0x202:
  - o_be=1100;
  - o_wdata=0xABCDABCD;
  - o_addr=0x200;
  - o_we=1.
- Word load at 0x101:
  - no o_req;
  - o_misalign pulse;
  - o_wb_valid=0.
- Load with no ack (MAX_WAIT=4):
  - o_req high for 4 cycles;
  - o_timeout pulse;
  - FSM back to IDLE.
- Two further cases:
  - bne with i_Zero=0 gives o_PCSrc=1;
  - nrst dropped mid-BUSY clears o_req and WB outputs to 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the memory-access stage: access-size encodings, FSM states
// and the registered MEM/WB bundle.
package mips_pkg;

   localparam int DW = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mau_state_e;

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] mem_data;
      logic [DW-1:0] alu_data;
      logic          mem2reg;
      logic          regwrite;
   } wb_bundle_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word accesses: byte enables, replicated store
// data, extended load data and alignment check.
module mem_lane_align
   import mips_pkg::*;
(
   input  logic [1:0]    i_size,
   input  logic [1:0]    i_lane,
   input  logic          i_unsigned,
   input  logic [DW-1:0] i_wdata,
   input  logic [DW-1:0] i_rdata,
   output logic [3:0]    o_be,
   output logic [DW-1:0] o_wdata,
   output logic [DW-1:0] o_ldata,
   output logic          o_misalign
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = i_rdata[{i_lane, 3'b000} +: 8];
   assign half_sel = i_rdata[{i_lane[1], 4'b0000} +: 16];

   always_comb begin
      o_be       = 4'b1111;
      o_wdata    = i_wdata;
      o_ldata    = i_rdata;
      o_misalign = |i_lane;
      case (i_size)
         SZ_BYTE: begin
            o_be       = 4'b0001 << i_lane;
            o_wdata    = {4{i_wdata[7:0]}};
            o_ldata    = i_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            o_misalign = 1'b0;
         end
         SZ_HALF: begin
            o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
            o_wdata    = {2{i_wdata[15:0]}};
            o_ldata    = i_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            o_misalign = i_lane[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Registered memory-access stage between EX/MEM and WB with a req/ack data
// bus, stall, timeout, misalignment trap and beq/bne resolution.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access in flight; non-mem ops pass straight to WB
// ST_BUSY | request on the bus from latched values, waiting for ack
module mem_access_unit
   import mips_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  i_valid,
   input  logic                  i_MemRead,
   input  logic                  i_MemWrite,
   input  logic [1:0]            i_Size,
   input  logic                  i_Unsigned,
   input  logic                  i_Branch,
   input  logic                  i_BranchNe,
   input  logic                  i_Zero,
   input  logic [ADDR_W-1:0]     i_PCBranch,
   input  logic [DW-1:0]         i_ALUOut,
   input  logic [DW-1:0]         i_RTData,
   input  logic                  i_Mem2Reg,
   input  logic                  i_RegWrite,
   input  logic [REG_ADDR_W-1:0] i_RegAddrW,
   output logic                  o_stall,
   output logic                  o_PCSrc,
   output logic [ADDR_W-1:0]     o_PCBranch,
   output logic                  o_req,
   output logic                  o_we,
   output logic [ADDR_W-1:0]     o_addr,
   output logic [DW-1:0]         o_wdata,
   output logic [3:0]            o_be,
   input  logic                  i_ack,
   input  logic [DW-1:0]         i_rdata,
   output logic                  o_wb_valid,
   output logic [DW-1:0]         o_WB_MemData,
   output logic [DW-1:0]         o_WB_ALUData,
   output logic                  o_WB_Mem2Reg,
   output logic                  o_WB_RegWrite,
   output logic [REG_ADDR_W-1:0] o_WB_RegAddrW,
   output logic                  o_misalign,
   output logic                  o_timeout
);

   mau_state_e            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DW-1:0]         wdata_q, wdata_d;
   logic [3:0]            be_q, be_d;
   logic [1:0]            size_q, size_d, lane_q, lane_d;
   logic                  uns_q, uns_d;
   logic [DW-1:0]         alu_q, alu_d;
   logic                  m2r_q, m2r_d, rw_q, rw_d;
   logic [REG_ADDR_W-1:0] rad_q, rad_d;
   wb_bundle_t            wb_q, wb_d;
   logic [REG_ADDR_W-1:0] wb_rad_q, wb_rad_d;
   logic                  misalign_q, misalign_d, timeout_q, timeout_d;

   logic                  busy, mem_op;
   logic [1:0]            la_size, la_lane;
   logic                  la_uns, la_misalign;
   logic [3:0]            la_be;
   logic [DW-1:0]         la_wdata, la_ldata;

   assign busy   = (state_q == ST_BUSY);
   assign mem_op = i_valid & (i_MemRead | i_MemWrite);

   // One aligner serves both phases: live inputs at accept, latched ones on ack.
   assign la_size = busy ? size_q : i_Size;
   assign la_lane = busy ? lane_q : i_ALUOut[1:0];
   assign la_uns  = busy ? uns_q  : i_Unsigned;

   mem_lane_align u_align (
      .i_size     (la_size),
      .i_lane     (la_lane),
      .i_unsigned (la_uns),
      .i_wdata    (i_RTData),
      .i_rdata    (i_rdata),
      .o_be       (la_be),
      .o_wdata    (la_wdata),
      .o_ldata    (la_ldata),
      .o_misalign (la_misalign)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      size_d     = size_q;
      lane_d     = lane_q;
      uns_d      = uns_q;
      alu_d      = alu_q;
      m2r_d      = m2r_q;
      rw_d       = rw_q;
      rad_d      = rad_q;
      wb_d       = wb_q;
      wb_d.valid = 1'b0;
      wb_rad_d   = wb_rad_q;
      misalign_d = 1'b0;
      timeout_d  = 1'b0;
      o_stall    = 1'b0;

      if (!busy) begin
         if (mem_op) begin
            if (la_misalign) begin
               misalign_d = 1'b1;
            end else begin
               o_stall = 1'b1;
               state_d = ST_BUSY;
               cnt_d   = 8'd1;
               req_d   = 1'b1;
               we_d    = i_MemWrite;
               addr_d  = ADDR_W'(i_ALUOut) & ~ADDR_W'(3);
               wdata_d = la_wdata;
               be_d    = la_be;
               size_d  = i_Size;
               lane_d  = i_ALUOut[1:0];
               uns_d   = i_Unsigned;
               alu_d   = i_ALUOut;
               m2r_d   = i_Mem2Reg;
               rw_d    = i_RegWrite;
               rad_d   = i_RegAddrW;
            end
         end else begin
            wb_d.valid    = i_valid;
            wb_d.mem_data = '0;
            wb_d.alu_data = i_ALUOut;
            wb_d.mem2reg  = i_Mem2Reg;
            wb_d.regwrite = i_RegWrite;
            wb_rad_d      = i_RegAddrW;
         end
      end else begin
         o_stall = ~i_ack;
         // Ack wins over timeout when both land in the same cycle.
         if (i_ack) begin
            wb_d.valid    = 1'b1;
            wb_d.mem_data = la_ldata;
            wb_d.alu_data = alu_q;
            wb_d.mem2reg  = m2r_q;
            wb_d.regwrite = rw_q;
            wb_rad_d      = rad_q;
            state_d       = ST_IDLE;
            cnt_d         = 8'd0;
            req_d         = 1'b0;
            we_d          = 1'b0;
         end else if (cnt_q == 8'(MAX_WAIT)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = 8'd0;
            req_d     = 1'b0;
            we_d      = 1'b0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         size_q     <= '0;
         lane_q     <= '0;
         uns_q      <= 1'b0;
         alu_q      <= '0;
         m2r_q      <= 1'b0;
         rw_q       <= 1'b0;
         rad_q      <= '0;
         wb_q       <= '0;
         wb_rad_q   <= '0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         size_q     <= size_d;
         lane_q     <= lane_d;
         uns_q      <= uns_d;
         alu_q      <= alu_d;
         m2r_q      <= m2r_d;
         rw_q       <= rw_d;
         rad_q      <= rad_d;
         wb_q       <= wb_d;
         wb_rad_q   <= wb_rad_d;
         misalign_q <= misalign_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_PCSrc       = i_valid & i_Branch & (i_Zero ^ i_BranchNe);
   assign o_PCBranch    = i_PCBranch;
   assign o_req         = req_q;
   assign o_we          = we_q;
   assign o_addr        = addr_q;
   assign o_wdata       = wdata_q;
   assign o_be          = be_q;
   assign o_wb_valid    = wb_q.valid;
   assign o_WB_MemData  = wb_q.mem_data;
   assign o_WB_ALUData  = wb_q.alu_data;
   assign o_WB_Mem2Reg  = wb_q.mem2reg;
   assign o_WB_RegWrite = wb_q.regwrite;
   assign o_WB_RegAddrW = wb_rad_q;
   assign o_misalign    = misalign_q;
   assign o_timeout     = timeout_q;

endmodule
